// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared bus bundle for the fetch port, the data port and the memory port
//
// Signals:
//   i_req/i_addr                  fetch request in      i_rdata/i_ready      fetch completion out
//   d_req/d_we/d_addr/d_width/d_wdata  data request in   d_rdata/d_ready      data completion out
//   mem_req/mem_we/mem_addr/mem_width/mem_wdata  memory request out
//   mem_rdata/mem_ack             memory completion in
//   err                           watchdog abort pulse  grant_d              access owner flag
// Modports: slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [2:0]  d_width;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_width;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        err;
    logic        grant_d;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_width, d_wdata,
        input  mem_rdata, mem_ack,
        output i_rdata, i_ready,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_width, mem_wdata,
        output err, grant_d
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_width, d_wdata,
        output mem_rdata, mem_ack,
        input  i_rdata, i_ready,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_width, mem_wdata,
        input  err, grant_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch (I) and data (D) accesses onto one variable-latency memory
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: I/D request ports, memory port, err and grant_d
// Parameters:
//   STARVE_MAX  consecutive contended D grants before I is forced to win
//   TIMEOUT     WAIT cycles without mem_ack before the access is aborted
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] WDOG_LIM   = TW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t         state, state_n;
    logic [SW-1:0]  starve, starve_n;
    logic [TW-1:0]  wdog, wdog_n;

    logic           mem_req_n, mem_we_n, grant_d_n;
    logic [31:0]    mem_addr_n, mem_wdata_n;
    logic [2:0]     mem_width_n;
    logic [31:0]    i_rdata_n, d_rdata_n;
    logic           i_ready_n, d_ready_n, err_n;

    // A port whose ready is high is still holding the request it just had
    // served, so it must not be granted again in the same cycle.
    logic i_elig, d_elig;
    assign i_elig = bus.i_req & ~bus.i_ready;
    assign d_elig = bus.d_req & ~bus.d_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            starve        <= '0;
            wdog          <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_width <= '0;
            bus.mem_wdata <= '0;
            bus.grant_d   <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.i_ready   <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_n;
            starve        <= starve_n;
            wdog          <= wdog_n;
            bus.mem_req   <= mem_req_n;
            bus.mem_we    <= mem_we_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_width <= mem_width_n;
            bus.mem_wdata <= mem_wdata_n;
            bus.grant_d   <= grant_d_n;
            bus.i_rdata   <= i_rdata_n;
            bus.d_rdata   <= d_rdata_n;
            bus.i_ready   <= i_ready_n;
            bus.d_ready   <= d_ready_n;
            bus.err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        starve_n    = starve;
        wdog_n      = wdog;
        mem_req_n   = bus.mem_req;
        mem_we_n    = bus.mem_we;
        mem_addr_n  = bus.mem_addr;
        mem_width_n = bus.mem_width;
        mem_wdata_n = bus.mem_wdata;
        grant_d_n   = bus.grant_d;
        i_rdata_n   = bus.i_rdata;
        d_rdata_n   = bus.d_rdata;
        i_ready_n   = 1'b0;
        d_ready_n   = 1'b0;
        err_n       = 1'b0;

        case (state)
            S_IDLE: begin
                if (d_elig && !(i_elig && starve == STARVE_LIM)) begin
                    state_n     = S_WAIT;
                    mem_req_n   = 1'b1;
                    grant_d_n   = 1'b1;
                    mem_we_n    = bus.d_we;
                    mem_addr_n  = bus.d_addr;
                    mem_width_n = bus.d_width;
                    mem_wdata_n = bus.d_wdata;
                    wdog_n      = '0;
                    // D only wins a contended grant below the limit, so the
                    // increment cannot overflow past STARVE_LIM.
                    starve_n    = i_elig ? starve + 1'b1 : '0;
                end else if (i_elig) begin
                    state_n     = S_WAIT;
                    mem_req_n   = 1'b1;
                    grant_d_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = bus.i_addr;
                    mem_width_n = 3'b010;
                    mem_wdata_n = '0;
                    wdog_n      = '0;
                    starve_n    = '0;
                end
            end
            S_WAIT: begin
                if (bus.mem_ack) begin
                    state_n   = S_IDLE;
                    mem_req_n = 1'b0;
                    grant_d_n = 1'b0;
                    if (bus.grant_d) begin
                        d_ready_n = 1'b1;
                        if (!bus.mem_we) begin
                            d_rdata_n = bus.mem_rdata;
                        end
                    end else begin
                        i_ready_n = 1'b1;
                        i_rdata_n = bus.mem_rdata;
                    end
                end else if (wdog == WDOG_LIM) begin
                    // Hung access: complete it with zero data and flag err so
                    // the pipeline is released rather than stalled forever.
                    state_n   = S_IDLE;
                    mem_req_n = 1'b0;
                    grant_d_n = 1'b0;
                    err_n     = 1'b1;
                    if (bus.grant_d) begin
                        d_ready_n = 1'b1;
                        d_rdata_n = '0;
                    end else begin
                        i_ready_n = 1'b1;
                        i_rdata_n = '0;
                    end
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int SMAX = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the memory, how long it has
    // waited, how many contended D wins in a row, and the expected outputs.
    bit          m_busy;
    bit          m_own_d;
    int          m_noack;
    int          m_starve;
    logic        e_req, e_we, e_ir, e_dr, e_err, e_gd;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;
    logic [2:0]  e_width;

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_noack = 0; m_starve = 0;
        e_req = 0; e_we = 0; e_ir = 0; e_dr = 0; e_err = 0; e_gd = 0;
        e_addr = 0; e_wdata = 0; e_ird = 0; e_drd = 0; e_width = 0;
    endtask

    task automatic finish_access(input bit aborted, input logic [31:0] data);
        m_busy = 0;
        e_req  = 0;
        e_gd   = 0;
        e_err  = aborted;
        if (m_own_d) begin
            e_dr = 1;
            if (aborted) e_drd = 0;
            else if (!e_we) e_drd = data;
        end else begin
            e_ir  = 1;
            e_ird = aborted ? 32'h0 : data;
        end
    endtask

    // Predicts outputs after the next rising edge from the inputs driven now.
    task automatic model_next();
        bit ie, de;
        ie = bus.i_req && !e_ir;
        de = bus.d_req && !e_dr;
        e_ir = 0; e_dr = 0; e_err = 0;
        if (!m_busy) begin
            if (de && !(ie && m_starve == SMAX)) begin
                m_busy = 1; m_own_d = 1; m_noack = 0;
                m_starve = ie ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
                e_req = 1; e_gd = 1;
                e_we = bus.d_we; e_addr = bus.d_addr; e_width = bus.d_width; e_wdata = bus.d_wdata;
            end else if (ie) begin
                m_busy = 1; m_own_d = 0; m_noack = 0; m_starve = 0;
                e_req = 1; e_gd = 0;
                e_we = 0; e_addr = bus.i_addr; e_width = 3'b010; e_wdata = 0;
            end
        end else if (bus.mem_ack) begin
            finish_access(1'b0, bus.mem_rdata);
        end else begin
            m_noack++;
            if (m_noack == TMO) finish_access(1'b1, 32'h0);
        end
    endtask

    task automatic compare_all();
        check("mem_req", 32'(bus.mem_req), 32'(e_req));
        check("grant_d", 32'(bus.grant_d), 32'(e_gd));
        check("i_ready", 32'(bus.i_ready), 32'(e_ir));
        check("d_ready", 32'(bus.d_ready), 32'(e_dr));
        check("err",     32'(bus.err),     32'(e_err));
        check("i_rdata", bus.i_rdata, e_ird);
        check("d_rdata", bus.d_rdata, e_drd);
        if (e_req) begin
            check("mem_we",    32'(bus.mem_we),    32'(e_we));
            check("mem_addr",  bus.mem_addr,       e_addr);
            check("mem_width", 32'(bus.mem_width), 32'(e_width));
            check("mem_wdata", bus.mem_wdata,      e_wdata);
        end
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    bit          i_act, d_act;
    int          ackpct;

    initial begin
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_width = 0; bus.d_wdata = 0;
        bus.mem_rdata = 0; bus.mem_ack = 0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_mem_width", 32'(bus.mem_width), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        step();

        // Lone fetch, ack three cycles after mem_req rises
        bus.i_req = 1; bus.i_addr = 32'h100;
        step();
        check("fetch_width", 32'(bus.mem_width), 32'h2);
        check("fetch_we", 32'(bus.mem_we), 32'h0);
        check("fetch_addr", bus.mem_addr, 32'h100);
        step();
        step();
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
        step();
        check("fetch_ready", 32'(bus.i_ready), 32'h1);
        check("fetch_rdata", bus.i_rdata, 32'hDEADBEEF);
        bus.i_req = 0; bus.mem_ack = 0;
        step();
        check("fetch_ready_pulse", 32'(bus.i_ready), 32'h0);

        // Contention with zero-wait memory: D first, then I
        bus.i_req = 1; bus.i_addr = 32'h300;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.d_width = 3'b010;
        bus.mem_ack = 1; bus.mem_rdata = 32'h11111111;
        step();
        check("cont_grant_d", 32'(bus.grant_d), 32'h1);
        check("cont_addr_d", bus.mem_addr, 32'h2000);
        step();
        check("cont_d_ready", 32'(bus.d_ready), 32'h1);
        bus.d_req = 0; bus.mem_rdata = 32'h22222222;
        step();
        check("cont_grant_i", 32'(bus.grant_d), 32'h0);
        check("cont_addr_i", bus.mem_addr, 32'h300);
        step();
        check("cont_i_ready", 32'(bus.i_ready), 32'h1);
        check("cont_i_rdata", bus.i_rdata, 32'h22222222);
        bus.i_req = 0; bus.mem_ack = 0;
        step();

        // Store leaves d_rdata alone
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h55AA; bus.d_width = 3'b000;
        step();
        check("st_we", 32'(bus.mem_we), 32'h1);
        check("st_addr", bus.mem_addr, 32'h40);
        check("st_wdata", bus.mem_wdata, 32'h55AA);
        check("st_width", 32'(bus.mem_width), 32'h0);
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
        step();
        check("st_ready", 32'(bus.d_ready), 32'h1);
        check("st_rdata_kept", bus.d_rdata, 32'h11111111);
        bus.d_req = 0; bus.d_we = 0; bus.mem_ack = 0;
        step();

        // Watchdog abort after TMO WAIT cycles
        bus.i_req = 1; bus.i_addr = 32'h500;
        step();
        for (int k = 0; k < TMO - 1; k++) begin
            step();
            check("tmo_req_held", 32'(bus.mem_req), 32'h1);
        end
        step();
        check("tmo_ready", 32'(bus.i_ready), 32'h1);
        check("tmo_err", 32'(bus.err), 32'h1);
        check("tmo_rdata", bus.i_rdata, 32'h0);
        check("tmo_mem_req", 32'(bus.mem_req), 32'h0);
        bus.i_req = 0;
        step();

        // Asynchronous reset mid-WAIT drops the access
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
        step();
        check("rw_req_before", 32'(bus.mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_req_async", 32'(bus.mem_req), 32'h0);
        check("rw_grant_async", 32'(bus.grant_d), 32'h0);
        model_reset();
        bus.d_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rw_no_ready", 32'(bus.d_ready), 32'h0);
        end

        // Randomized traffic against the reference model
        i_act = 0; d_act = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (i_act && e_ir) i_act = 0;
            if (d_act && e_dr) d_act = 0;
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1;
                bus.i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1;
                bus.d_we    = $urandom_range(0, 1);
                bus.d_addr  = $urandom;
                bus.d_width = 3'($urandom_range(0, 7));
                bus.d_wdata = $urandom;
            end
            bus.i_req = i_act;
            bus.d_req = d_act;
            ackpct = ((cyc / 400) % 3 == 2) ? 5 : 50;
            bus.mem_ack   = bus.mem_req && ($urandom_range(0, 99) < ackpct);
            bus.mem_rdata = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
